// File: rtl/uart_port_arbiter.sv
// Round-robin owner arbiter for the shared board UART byte channel.
// Optional idle-timeout revoke is built when UART_ARB_TIMEOUT_EN is defined.
module uart_port_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte_out,
  input  logic [N_REQ-1:0]   req_start_send,
  input  logic [N_REQ-1:0]   req_start_receive,
  output logic [N_REQ-1:0]   grant,
  output logic [2*N_REQ-1:0] req_response,
  output logic [7:0]         UART_BYTE_OUT,
  output logic               UART_START_SEND,
  output logic               UART_START_RECEIVE,
  input  logic [1:0]         UART_RESPONSE,
  output logic [IDW-1:0]     owner_id,
  output logic               busy,
  output logic               timeout_evt
);

  typedef enum logic [1:0] {StIdle, StOwn, StDrain, StGap} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick;
  logic             in_flight_q, in_flight_d;
  logic             found, passed_start, resp_any, tmo_fire, holding;
  logic [N_REQ-1:0] eligible;

  assign holding      = (state_q == StOwn) || (state_q == StDrain);
  assign resp_any     = |UART_RESPONSE;
  assign passed_start = (state_q == StOwn) &&
                        (req_start_send[owner_q] || req_start_receive[owner_q]);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] blk_q, blk_d;
  logic             tmo_evt_q;

  assign tmo_fire = holding && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign eligible = req & ~blk_q;
  assign timeout_evt = tmo_evt_q;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!holding || passed_start || resp_any || tmo_fire) cnt_d = '0;
    // A revoked requester stays masked until it drops its request.
    blk_d = (blk_q & req) | (tmo_fire ? grant_q : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      blk_q     <= '0;
      tmo_evt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      tmo_evt_q <= tmo_fire;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign eligible    = req;
  assign timeout_evt = 1'b0;
`endif

  // Descending scan so the smallest offset after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (eligible[(int'(rr_ptr_q) + i) % int'(N_REQ)]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr_ptr_q) + i) % int'(N_REQ));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IDW'(N_REQ - 1);
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      in_flight_q <= in_flight_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    in_flight_d = in_flight_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StOwn;
          grant_d  = N_REQ'(1) << pick;
          owner_d  = pick;
          rr_ptr_d = pick;
        end
      end
      StOwn: begin
        // Old transfer retires before a same-cycle start re-arms in_flight.
        in_flight_d = (in_flight_q && !resp_any) || passed_start;
        if (tmo_fire) begin
          in_flight_d = 1'b0;
          grant_d     = '0;
          state_d     = StGap;
        end else if (!req[owner_q]) begin
          if (in_flight_d) begin
            state_d = StDrain;
          end else begin
            grant_d = '0;
            state_d = StGap;
          end
        end
      end
      StDrain: begin
        if (resp_any || tmo_fire) begin
          in_flight_d = 1'b0;
          grant_d     = '0;
          state_d     = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant              = grant_q;
    owner_id           = owner_q;
    busy               = holding;
    UART_BYTE_OUT      = 8'h00;
    UART_START_SEND    = 1'b0;
    UART_START_RECEIVE = 1'b0;
    req_response       = '0;
    if (holding) begin
      UART_BYTE_OUT                = req_byte_out[8*owner_q +: 8];
      req_response[2*owner_q +: 2] = UART_RESPONSE;
    end
    if (state_q == StOwn) begin
      UART_START_SEND    = req_start_send[owner_q];
      UART_START_RECEIVE = req_start_receive[owner_q];
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Self-checking bench for uart_port_arbiter: directed scenarios plus
// randomized ownership sessions checked against a round-robin reference model.
module tb_uart_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_byte_out = '0;
  logic [3:0]  req_start_send = '0;
  logic [3:0]  req_start_receive = '0;
  logic [3:0]  grant;
  logic [7:0]  req_response;
  logic [7:0]  UART_BYTE_OUT;
  logic        UART_START_SEND;
  logic        UART_START_RECEIVE;
  logic [1:0]  UART_RESPONSE = '0;
  logic [1:0]  owner_id;
  logic        busy;
  logic        timeout_evt;

  int checks = 0;
  int failures = 0;
  int last = 3;

  always #5 clk = ~clk;

  uart_port_arbiter #(
    .N_REQ(4),
    .IDW  (2)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_byte_out      (req_byte_out),
    .req_start_send    (req_start_send),
    .req_start_receive (req_start_receive),
    .grant             (grant),
    .req_response      (req_response),
    .UART_BYTE_OUT     (UART_BYTE_OUT),
    .UART_START_SEND   (UART_START_SEND),
    .UART_START_RECEIVE(UART_START_RECEIVE),
    .UART_RESPONSE     (UART_RESPONSE),
    .owner_id          (owner_id),
    .busy              (busy),
    .timeout_evt       (timeout_evt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requester strictly after the last owner, modulo 4.
  function automatic int rr_pick(input int prev, input logic [3:0] m);
    for (int off = 1; off <= 4; off++) begin
      if (m[(prev + off) % 4]) return (prev + off) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

  task automatic wait_grant(input string tag, input int exp_idx);
    int n;
    n = 0;
    while (grant == 4'b0000 && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(grant), 32'(onehot(exp_idx)));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_byte"}, 32'(UART_BYTE_OUT), 32'h0);
    chk({tag, "_strobes"}, {30'd0, UART_START_SEND, UART_START_RECEIVE}, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    int exp_idx, other, nbytes, recv, dly;
    logic [3:0] mask;

    // Reset state
    #1;
    check_quiet("reset");
    chk("reset_owner", 32'(owner_id), 32'h0);
    chk("reset_resp", 32'(req_response), 32'h0);
    chk("reset_tmo", 32'(timeout_evt), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Round robin with all requests held; each owner releases after one byte
    req = 4'b1111;
    tick();
    chk("first_grant", 32'(grant), 32'h1);
    for (int n = 0; n < 5; n++) begin
      exp_idx = rr_pick(last, 4'b1111);
      wait_grant("rr_grant", exp_idx);
      chk("rr_owner", 32'(owner_id), 32'(exp_idx));
      last = exp_idx;
      req_byte_out[8*exp_idx +: 8] = 8'h30 + 8'(n);
      req_start_send[exp_idx] = 1'b1;
      #1;
      chk("rr_byte", 32'(UART_BYTE_OUT), 32'h30 + 32'(n));
      tick();
      req_start_send = '0;
      UART_RESPONSE = 2'b01;
      #1;
      chk("rr_resp", 32'(req_response), 32'(8'b01 << (2 * exp_idx)));
      tick();
      UART_RESPONSE = '0;
      req[exp_idx] = 1'b0;
      tick();
      chk("rr_gap", 32'(grant), 32'h0);
      req[exp_idx] = 1'b1;
    end
    req = '0;
    tick();
    tick();

    // Multi-byte ownership by requester 2 while requester 1 also requests
    req = 4'b0100;
    tick();
    exp_idx = rr_pick(last, 4'b0100);
    chk("mb_grant", 32'(grant), 32'(onehot(exp_idx)));
    last = exp_idx;
    req = 4'b0110;
    for (int n = 0; n < 4; n++) begin
      req_byte_out[23:16] = 8'h41 + 8'(n);
      req_byte_out[15:8]  = 8'hEE;
      req_start_send = 4'b0110;
      #1;
      chk("mb_byte", 32'(UART_BYTE_OUT), 32'h41 + 32'(n));
      chk("mb_send", 32'(UART_START_SEND), 32'h1);
      tick();
      req_start_send = '0;
      UART_RESPONSE = 2'b01;
      #1;
      chk("mb_slot1", 32'(req_response[3:2]), 32'h0);
      chk("mb_slot2", 32'(req_response[5:4]), 32'h1);
      tick();
      UART_RESPONSE = '0;
    end
    req = 4'b0010;
    tick();
    chk("mb_gap", 32'(grant), 32'h0);
    exp_idx = rr_pick(last, 4'b0010);
    wait_grant("mb_next", exp_idx);
    last = exp_idx;

    // Drain: owner 1 drops req one cycle after start_send
    req_byte_out[15:8] = 8'h55;
    req_start_send = 4'b0010;
    tick();
    req_start_send = '0;
    req = 4'b1000;
    tick();
    chk("drain_hold", 32'(grant), 32'h2);
    chk("drain_busy", 32'(busy), 32'h1);
    req_start_send = 4'b1000;
    #1;
    chk("drain_nonowner", 32'(UART_START_SEND), 32'h0);
    tick();
    req_start_send = '0;
    for (int n = 0; n < 2; n++) begin
      chk("drain_wait", 32'(grant), 32'h2);
      tick();
    end
    UART_RESPONSE = 2'b01;
    #1;
    chk("drain_resp", 32'(req_response), 32'h04);
    tick();
    UART_RESPONSE = '0;
    chk("drain_gap", 32'(grant), 32'h0);
    exp_idx = rr_pick(last, 4'b1000);
    wait_grant("drain_next", exp_idx);
    last = exp_idx;

    // Start strobe in the same cycle as a response keeps a transfer in flight
    req_byte_out[31:24] = 8'h61;
    req_start_send = 4'b1000;
    tick();
    req_start_send = '0;
    tick();
    req_byte_out[31:24] = 8'h62;
    req_start_send = 4'b1000;
    UART_RESPONSE = 2'b01;
    #1;
    chk("simul_send", 32'(UART_START_SEND), 32'h1);
    tick();
    req_start_send = '0;
    UART_RESPONSE = '0;
    req = '0;
    tick();
    chk("simul_drain", 32'(grant), 32'h8);
    UART_RESPONSE = 2'b01;
    tick();
    UART_RESPONSE = '0;
    chk("simul_gap", 32'(grant), 32'h0);
    tick();

    // Reset asserted during DRAIN
    req = 4'b1000;
    tick();
    exp_idx = rr_pick(last, 4'b1000);
    chk("rst_pre_grant", 32'(grant), 32'(onehot(exp_idx)));
    req_start_send = 4'b1000;
    tick();
    req_start_send = '0;
    req = '0;
    tick();
    chk("rst_in_drain", 32'(grant), 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("rst_async");
    chk("rst_async_owner", 32'(owner_id), 32'h0);
    last = 3;
    req = 4'b0100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rst_regrant", 32'(grant), 32'h4);
    last = 2;
    req = '0;
    tick();
    tick();

    // Randomized ownership sessions
    for (int s = 0; s < 20; s++) begin
      mask = 4'($urandom_range(1, 15));
      exp_idx = rr_pick(last, mask);
      req = mask;
      tick();
      chk("rnd_grant", 32'(grant), 32'(onehot(exp_idx)));
      chk("rnd_owner", 32'(owner_id), 32'(exp_idx));
      last = exp_idx;
      nbytes = $urandom_range(1, 3);
      for (int k = 0; k < nbytes; k++) begin
        b = 8'($urandom);
        recv = $urandom_range(0, 1);
        other = (exp_idx + 1 + $urandom_range(0, 2)) % 4;
        req_byte_out = $urandom;
        req_byte_out[8*exp_idx +: 8] = b;
        req_start_send[other] = 1'b1;
        if (recv == 1) req_start_receive[exp_idx] = 1'b1;
        else req_start_send[exp_idx] = 1'b1;
        #1;
        chk("rnd_byte", 32'(UART_BYTE_OUT), 32'(b));
        chk("rnd_send", 32'(UART_START_SEND), 32'(recv == 0));
        chk("rnd_recv", 32'(UART_START_RECEIVE), 32'(recv == 1));
        tick();
        req_start_send = '0;
        req_start_receive = '0;
        dly = $urandom_range(0, 2);
        repeat (dly) tick();
        UART_RESPONSE = (recv == 1) ? 2'b10 : 2'b01;
        #1;
        chk("rnd_route", 32'(req_response), 32'({6'd0, UART_RESPONSE} << (2 * exp_idx)));
        tick();
        UART_RESPONSE = '0;
      end
      req = '0;
      tick();
      check_quiet("rnd_gap");
      tick();
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Idle owner is revoked 16 cycles after grant
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0011;
    tick();
    chk("tmo_grant", 32'(grant), 32'h1);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk("tmo_early", {30'd0, timeout_evt, grant[0]}, 32'h1);
    end
    tick();
    chk("tmo_pulse", 32'(timeout_evt), 32'h1);
    chk("tmo_gap", 32'(grant), 32'h0);
    tick();
    chk("tmo_single", 32'(timeout_evt), 32'h0);
    wait_grant("tmo_next", 1);
`else
    chk("tmo_tied", 32'(timeout_evt), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
